flow_ram_arbiter: RTL and testbench

- Shares the single flow-RAM port of sram_reset_intf between two clients.
  - Client A: packet-path flow lookup/update, high priority.
  - Client B: flow-table timeout scanner, low priority.
- Read and write channels are arbitrated independently. Fixed priority applies, with an anti-starvation override for B.
- Read responses are returned to the client that issued them, using an in-order tag FIFO.
- Sits between the flow-table engines and sram_reset_intf.

---
 rtl/flow_ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_flow_ram_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_ram_arbiter.sv
// Two-client arbiter for the flow-RAM port: A (packet path) has priority, B (timeout scanner) gets an anti-starvation grant.
// Optional macro FLOW_ARB_RAW_HAZARD_EN holds back a read that targets the address being written in the same cycle.
`ifndef FLOW_RAM_ADDR_WIDTH
`define FLOW_RAM_ADDR_WIDTH 16
`endif
`ifndef FLOW_RAM_WORD_WIDTH
`define FLOW_RAM_WORD_WIDTH 32
`endif

module flow_ram_arbiter #(
    parameter int ADDR_WIDTH   = `FLOW_RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH   = `FLOW_RAM_WORD_WIDTH,
    parameter int MAX_PENDING  = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_read_en,
    input  logic [ADDR_WIDTH-1:0] a_read_addr,
    output logic                  a_read_ack,
    output logic                  a_read_data_new,
    input  logic                  a_write_en,
    input  logic [ADDR_WIDTH-1:0] a_write_addr,
    input  logic [DATA_WIDTH-1:0] a_write_data,
    output logic                  a_write_ack,
    input  logic                  b_read_en,
    input  logic [ADDR_WIDTH-1:0] b_read_addr,
    output logic                  b_read_ack,
    output logic                  b_read_data_new,
    input  logic                  b_write_en,
    input  logic [ADDR_WIDTH-1:0] b_write_addr,
    input  logic [DATA_WIDTH-1:0] b_write_data,
    output logic                  b_write_ack,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  mem_write_ready,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  mem_read_ready,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_read_data_new,
    output logic                  err_orphan
);

    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [PTR_W:0] FIFO_FULL  = (PTR_W + 1)'(MAX_PENDING);

    logic [MAX_PENDING-1:0] tagMem_q;
    logic [PTR_W-1:0]       wrPtr_q, rdPtr_q;
    logic [PTR_W:0]         tagCount_q;
    logic [SW-1:0]          readStarve_q, readStarve_d;
    logic [SW-1:0]          writeStarve_q, writeStarve_d;
    logic [DATA_WIDTH-1:0]  readData_q;
    logic                   aNew_q, bNew_q, errOrphan_q;

    logic                   tagPop, tagOrphan;
    logic                   readEligible, readPickB, readHazard, readGrant;
    logic                   writePickB, writeGrant;
    logic [ADDR_WIDTH-1:0]  readSelAddr;

    // A push and a pop may coincide, so a full FIFO still accepts a read while a response drains it.
    always_comb begin
        tagPop       = mem_read_data_new && (tagCount_q != '0);
        tagOrphan    = mem_read_data_new && (tagCount_q == '0);

        writePickB   = b_write_en && (!a_write_en || (writeStarve_q == STARVE_MAX));
        writeGrant   = mem_write_ready && (a_write_en || b_write_en);

        readEligible = mem_read_ready && ((tagCount_q != FIFO_FULL) || tagPop);
        readPickB    = b_read_en && (!a_read_en || (readStarve_q == STARVE_MAX));
        readSelAddr  = readPickB ? b_read_addr : a_read_addr;
`ifdef FLOW_ARB_RAW_HAZARD_EN
        readHazard   = writeGrant && (mem_write_addr == readSelAddr);
`else
        readHazard   = 1'b0;
`endif
        readGrant    = readEligible && (a_read_en || b_read_en) && !readHazard;
    end

    assign a_write_ack    = writeGrant && !writePickB;
    assign b_write_ack    = writeGrant && writePickB;
    assign mem_write_en   = writeGrant;
    assign mem_write_addr = writePickB ? b_write_addr : a_write_addr;
    assign mem_write_data = writePickB ? b_write_data : a_write_data;

    assign a_read_ack     = readGrant && !readPickB;
    assign b_read_ack     = readGrant && readPickB;
    assign mem_read_en    = readGrant;
    assign mem_read_addr  = readGrant ? readSelAddr : '0;

    assign read_data       = readData_q;
    assign a_read_data_new = aNew_q;
    assign b_read_data_new = bNew_q;
    assign err_orphan      = errOrphan_q;

    // Starvation counters only advance while the channel could actually have granted something.
    always_comb begin
        readStarve_d = readStarve_q;
        if (!b_read_en || b_read_ack) begin
            readStarve_d = '0;
        end else if (readEligible && (readStarve_q != STARVE_MAX)) begin
            readStarve_d = readStarve_q + SW'(1);
        end

        writeStarve_d = writeStarve_q;
        if (!b_write_en || b_write_ack) begin
            writeStarve_d = '0;
        end else if (mem_write_ready && (writeStarve_q != STARVE_MAX)) begin
            writeStarve_d = writeStarve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tagMem_q      <= '0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            tagCount_q    <= '0;
            readStarve_q  <= '0;
            writeStarve_q <= '0;
            readData_q    <= '0;
            aNew_q        <= 1'b0;
            bNew_q        <= 1'b0;
            errOrphan_q   <= 1'b0;
        end else begin
            readStarve_q  <= readStarve_d;
            writeStarve_q <= writeStarve_d;
            aNew_q        <= tagPop && !tagMem_q[rdPtr_q];
            bNew_q        <= tagPop && tagMem_q[rdPtr_q];
            if (readGrant) begin
                tagMem_q[wrPtr_q] <= readPickB;
                wrPtr_q           <= wrPtr_q + PTR_W'(1);
            end
            if (tagPop) begin
                rdPtr_q    <= rdPtr_q + PTR_W'(1);
                readData_q <= mem_read_data;
            end
            case ({readGrant, tagPop})
                2'b10:   tagCount_q <= tagCount_q + (PTR_W + 1)'(1);
                2'b01:   tagCount_q <= tagCount_q - (PTR_W + 1)'(1);
                default: tagCount_q <= tagCount_q;
            endcase
            if (tagOrphan) begin
                errOrphan_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flow_ram_arbiter.sv
// Directed bench for flow_ram_arbiter: grants, starvation override, tag routing, FIFO full, orphan and hazard handling.
// Inputs change on the falling edge; outputs are checked 1 ns later, away from the rising edge.
module tb_flow_ram_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          a_read_en, a_read_ack, a_read_data_new;
    logic [AW-1:0] a_read_addr;
    logic          a_write_en, a_write_ack;
    logic [AW-1:0] a_write_addr;
    logic [DW-1:0] a_write_data;
    logic          b_read_en, b_read_ack, b_read_data_new;
    logic [AW-1:0] b_read_addr;
    logic          b_write_en, b_write_ack;
    logic [AW-1:0] b_write_addr;
    logic [DW-1:0] b_write_data;
    logic [DW-1:0] read_data;
    logic          mem_write_ready, mem_write_en;
    logic [AW-1:0] mem_write_addr;
    logic [DW-1:0] mem_write_data;
    logic          mem_read_ready, mem_read_en;
    logic [AW-1:0] mem_read_addr;
    logic [DW-1:0] mem_read_data;
    logic          mem_read_data_new;
    logic          err_orphan;

    int errors = 0;
    int checks = 0;

    flow_ram_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_PENDING(8), .STARVE_LIMIT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .a_read_en(a_read_en), .a_read_addr(a_read_addr), .a_read_ack(a_read_ack),
        .a_read_data_new(a_read_data_new),
        .a_write_en(a_write_en), .a_write_addr(a_write_addr), .a_write_data(a_write_data),
        .a_write_ack(a_write_ack),
        .b_read_en(b_read_en), .b_read_addr(b_read_addr), .b_read_ack(b_read_ack),
        .b_read_data_new(b_read_data_new),
        .b_write_en(b_write_en), .b_write_addr(b_write_addr), .b_write_data(b_write_data),
        .b_write_ack(b_write_ack),
        .read_data(read_data),
        .mem_write_ready(mem_write_ready), .mem_write_en(mem_write_en),
        .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
        .mem_read_ready(mem_read_ready), .mem_read_en(mem_read_en),
        .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
        .mem_read_data_new(mem_read_data_new),
        .err_orphan(err_orphan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ren, input logic [AW-1:0] raddr,
                                 input logic rdnew, input logic [DW-1:0] rdata);
        a_read_en         = ren;
        a_read_addr       = raddr;
        mem_read_data_new = rdnew;
        mem_read_data     = rdata;
    endtask

    initial begin
        reset = 1'b1;
        a_read_en = 0; a_read_addr = 0; a_write_en = 0; a_write_addr = 0; a_write_data = 0;
        b_read_en = 0; b_read_addr = 0; b_write_en = 0; b_write_addr = 0; b_write_data = 0;
        mem_write_ready = 0; mem_read_ready = 0; mem_read_data = 0; mem_read_data_new = 0;

        @(negedge clk); #1;
        checkOutput("rst_read_data", read_data, 0);
        checkOutput("rst_err_orphan", {31'd0, err_orphan}, 0);
        checkOutput("rst_a_new", {31'd0, a_read_data_new}, 0);
        checkOutput("rst_mem_read_en", {31'd0, mem_read_en}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single A read to address 5 and its response
        @(negedge clk);
        mem_read_ready = 1; mem_write_ready = 1;
        applyStimulus(1, 16'd5, 0, 0);
        #1;
        checkOutput("t1_a_ack", {31'd0, a_read_ack}, 1);
        checkOutput("t1_mem_en", {31'd0, mem_read_en}, 1);
        checkOutput("t1_mem_addr", {16'd0, mem_read_addr}, 5);
        checkOutput("t1_b_ack", {31'd0, b_read_ack}, 0);
        @(negedge clk);
        applyStimulus(0, 16'd0, 1, 32'd547856);
        #1;
        checkOutput("t1_a_new_early", {31'd0, a_read_data_new}, 0);
        @(negedge clk);
        applyStimulus(0, 16'd0, 0, 32'd0);
        #1;
        checkOutput("t1_a_new", {31'd0, a_read_data_new}, 1);
        checkOutput("t1_b_new", {31'd0, b_read_data_new}, 0);
        checkOutput("t1_data", read_data, 547856);
        @(negedge clk); #1;
        checkOutput("t1_a_new_off", {31'd0, a_read_data_new}, 0);
        checkOutput("t1_data_hold", read_data, 547856);

        // Continuous writes from both clients: B forced through on cycle 17
        @(negedge clk);
        a_write_en = 1; a_write_addr = 16'd12; a_write_data = 32'h1111;
        b_write_en = 1; b_write_addr = 16'd25; b_write_data = 32'h2222;
        for (int c = 1; c <= 18; c++) begin
            #1;
            checkOutput($sformatf("t2_a_wack_c%0d", c), {31'd0, a_write_ack}, (c != 17) ? 32'd1 : 32'd0);
            checkOutput($sformatf("t2_b_wack_c%0d", c), {31'd0, b_write_ack}, (c == 17) ? 32'd1 : 32'd0);
            if (c == 17) begin
                checkOutput("t2_waddr_b", {16'd0, mem_write_addr}, 25);
                checkOutput("t2_wdata_b", mem_write_data, 32'h2222);
            end
            @(negedge clk);
        end
        a_write_en = 0; b_write_en = 0;

        // Interleaved reads A(1), B(2), A(3) then in-order responses
        @(negedge clk);
        a_read_en = 1; a_read_addr = 16'd1; b_read_en = 1; b_read_addr = 16'd2;
        #1;
        checkOutput("t3_both_a_ack", {31'd0, a_read_ack}, 1);
        checkOutput("t3_both_b_ack", {31'd0, b_read_ack}, 0);
        @(negedge clk);
        a_read_en = 0;
        #1;
        checkOutput("t3_b_ack", {31'd0, b_read_ack}, 1);
        checkOutput("t3_b_addr", {16'd0, mem_read_addr}, 2);
        @(negedge clk);
        b_read_en = 0;
        applyStimulus(1, 16'd3, 0, 0);
        #1;
        checkOutput("t3_a_ack2", {31'd0, a_read_ack}, 1);
        @(negedge clk);
        applyStimulus(0, 16'd0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(0, 16'd0, 1, 32'd100);
        @(negedge clk);
        applyStimulus(0, 16'd0, 1, 32'd200);
        #1;
        checkOutput("t3_r0_a", {31'd0, a_read_data_new}, 1);
        checkOutput("t3_r0_b", {31'd0, b_read_data_new}, 0);
        checkOutput("t3_r0_data", read_data, 100);
        @(negedge clk);
        applyStimulus(0, 16'd0, 1, 32'd300);
        #1;
        checkOutput("t3_r1_a", {31'd0, a_read_data_new}, 0);
        checkOutput("t3_r1_b", {31'd0, b_read_data_new}, 1);
        checkOutput("t3_r1_data", read_data, 200);
        @(negedge clk);
        applyStimulus(0, 16'd0, 0, 0);
        #1;
        checkOutput("t3_r2_a", {31'd0, a_read_data_new}, 1);
        checkOutput("t3_r2_data", read_data, 300);
        checkOutput("t3_no_orphan", {31'd0, err_orphan}, 0);

        // Fill the tag FIFO with 8 reads, then swap one response for one request
        @(negedge clk);
        applyStimulus(1, 16'd50, 0, 0);
        for (int i = 0; i < 8; i++) begin
            #1;
            checkOutput($sformatf("t4_fill_ack%0d", i), {31'd0, a_read_ack}, 1);
            @(negedge clk);
        end
        #1;
        checkOutput("t4_full_ack", {31'd0, a_read_ack}, 0);
        checkOutput("t4_full_mem_en", {31'd0, mem_read_en}, 0);
        applyStimulus(1, 16'd50, 1, 32'd777);
        #1;
        checkOutput("t4_swap_ack", {31'd0, a_read_ack}, 1);
        @(negedge clk);
        applyStimulus(1, 16'd50, 0, 0);
        #1;
        checkOutput("t4_still_full", {31'd0, a_read_ack}, 0);
        checkOutput("t4_swap_new", {31'd0, a_read_data_new}, 1);
        checkOutput("t4_swap_data", read_data, 777);
        a_read_en = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 16'd0, 1, 32'd1000 + 32'(i));
            @(negedge clk);
        end
        applyStimulus(0, 16'd0, 0, 0);
        #1;
        checkOutput("t4_drain_new", {31'd0, a_read_data_new}, 1);
        checkOutput("t4_drain_data", read_data, 1007);
        checkOutput("t4_no_orphan", {31'd0, err_orphan}, 0);

        // Response with an empty FIFO sets the sticky orphan flag
        @(negedge clk);
        applyStimulus(0, 16'd0, 1, 32'd999);
        @(negedge clk);
        applyStimulus(0, 16'd0, 0, 0);
        #1;
        checkOutput("t5_orphan", {31'd0, err_orphan}, 1);
        checkOutput("t5_no_a_new", {31'd0, a_read_data_new}, 0);
        checkOutput("t5_no_b_new", {31'd0, b_read_data_new}, 0);
        checkOutput("t5_data_kept", read_data, 1007);
        @(negedge clk);
        @(negedge clk); #1;
        checkOutput("t5_orphan_sticky", {31'd0, err_orphan}, 1);
        reset = 1'b1;
        #1;
        checkOutput("t5_orphan_cleared", {31'd0, err_orphan}, 0);
        #1;
        reset = 1'b0;

        // Reset with a read outstanding discards its tag
        @(negedge clk);
        applyStimulus(1, 16'd7, 0, 0);
        #1;
        checkOutput("t6_ack", {31'd0, a_read_ack}, 1);
        @(negedge clk);
        applyStimulus(0, 16'd0, 0, 0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(0, 16'd0, 1, 32'd55);
        @(negedge clk);
        applyStimulus(0, 16'd0, 0, 0);
        #1;
        checkOutput("t6_orphan", {31'd0, err_orphan}, 1);
        checkOutput("t6_no_a_new", {31'd0, a_read_data_new}, 0);
        checkOutput("t6_data_zero", read_data, 0);
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;

        // Same-cycle read and write to address 42
        @(negedge clk);
        a_write_en = 1; a_write_addr = 16'd42; a_write_data = 32'd4242;
        applyStimulus(1, 16'd42, 0, 0);
        #1;
        checkOutput("t7_w_ack", {31'd0, a_write_ack}, 1);
`ifdef FLOW_ARB_RAW_HAZARD_EN
        checkOutput("t7_r_held", {31'd0, a_read_ack}, 0);
        @(negedge clk);
        a_write_en = 0;
        #1;
        checkOutput("t7_r_retry", {31'd0, a_read_ack}, 1);
        checkOutput("t7_r_addr", {16'd0, mem_read_addr}, 42);
`else
        checkOutput("t7_r_ack", {31'd0, a_read_ack}, 1);
        checkOutput("t7_r_addr", {16'd0, mem_read_addr}, 42);
`endif
        @(negedge clk);
        a_write_en = 0;
        applyStimulus(0, 16'd0, 0, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
